// File: rtl/m72_pkg.sv
// Shared types and constants for the M72 interrupt controller slice.
package m72_pkg;

  typedef enum logic [1:0] {
    READY,
    ICW2,
    ICW3,
    ICW4
  } pic_state_t;

  localparam logic [2:0] PIC_EOI_NS = 3'b001;
  localparam logic [2:0] PIC_EOI_SP = 3'b011;

endpackage

// File: rtl/pic_prio8.sv
// Lowest-set-bit encoder: bit 0 is the highest priority.
module pic_prio8
  import m72_pkg::*;
(
  input  logic [7:0] bits,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = '0;
    valid = |bits;
    for (int unsigned i = 8; i > 0; i--) begin
      if (bits[i-1]) idx = 3'(i - 1);
    end
  end

endmodule

// File: rtl/pic_71059.sv
// uPD71059-style 8-input priority interrupt controller for the V30 core.
// Optional feature: define PIC_AEOI_EN to honour the ICW4 auto-EOI bit.
module pic_71059
  import m72_pkg::*;
#(
  parameter int unsigned NUM_IR = 8
) (
  input  logic              CLK_32M,
  input  logic              reset,
  input  logic              CS,
  input  logic              A0,
  input  logic              IOWR,
  input  logic              IORD,
  input  logic [7:0]        DIN,
  output logic [7:0]        DOUT,
  input  logic [NUM_IR-1:0] IR,
  output logic              irq_rq,
  output logic [8:0]        irq_vector,
  input  logic              irq_ack
);

  pic_state_t state, state_n;
  logic [7:0] irr, isr, imr, ir_d, irr_n, isr_n;
  logic [3:0] t;
  logic [2:0] lvl, p_idx, s_idx;
  logic       p_vld, s_vld, pending;
  logic       ltim, sngl, ic4, ris, aeoi;
  logic       iowr_d, ack_d, wr, ack_take;
  logic       icw1, icw2_wr, icw4_wr, ocw1, ocw2, ocw3;

  pic_prio8 u_prio_req (.bits(irr & ~imr), .idx(p_idx), .valid(p_vld));
  pic_prio8 u_prio_isr (.bits(isr),        .idx(s_idx), .valid(s_vld));

  assign wr       = CS & IOWR & ~iowr_d;
  assign ack_take = irq_ack & ~ack_d & irq_rq;
  assign icw1     = wr & ~A0 & DIN[4];
  assign icw2_wr  = wr & A0 & (state == ICW2);
  assign icw4_wr  = wr & A0 & (state == ICW4);
  assign ocw1     = wr & A0 & (state == READY);
  assign ocw2     = wr & ~A0 & (DIN[4:3] == 2'b00) & (state == READY);
  assign ocw3     = wr & ~A0 & (DIN[4:3] == 2'b01) & (state == READY);
  assign pending  = p_vld & (~s_vld | (p_idx < s_idx)) & (state == READY);

  always_comb begin
    state_n = state;
    if (icw1) begin
      state_n = ICW2;
    end else if (wr && A0) begin
      case (state)
        ICW2:    state_n = !sngl ? ICW3 : (ic4 ? ICW4 : READY);
        ICW3:    state_n = ic4 ? ICW4 : READY;
        ICW4:    state_n = READY;
        default: state_n = state;
      endcase
    end
  end

  // Ack clears the served request before new edges are merged, so a fresh edge on the same line survives.
  always_comb begin
    irr_n = irr;
    if (ltim) begin
      irr_n = IR;
    end else begin
      if (ack_take) irr_n[lvl] = 1'b0;
      irr_n = irr_n | (IR & ~ir_d);
    end
    isr_n = isr;
    if (ocw2 && DIN[7:5] == PIC_EOI_NS && s_vld) isr_n[s_idx] = 1'b0;
    if (ocw2 && DIN[7:5] == PIC_EOI_SP) isr_n[DIN[2:0]] = 1'b0;
    if (ack_take && !aeoi) isr_n[lvl] = 1'b1;
  end

  always_comb begin
    DOUT = '0;
    if (CS && IORD) DOUT = A0 ? imr : (ris ? isr : irr);
  end

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state      <= READY;
      irr        <= '0;
      isr        <= '0;
      imr        <= '1;
      ir_d       <= '0;
      t          <= '0;
      ltim       <= 1'b0;
      sngl       <= 1'b0;
      ic4        <= 1'b0;
      ris        <= 1'b0;
      lvl        <= '0;
      iowr_d     <= 1'b0;
      ack_d      <= 1'b0;
      irq_rq     <= 1'b0;
      irq_vector <= '0;
    end else begin
      state  <= state_n;
      iowr_d <= IOWR;
      ack_d  <= irq_ack;
      if (icw1) begin
        ltim   <= DIN[3];
        sngl   <= DIN[1];
        ic4    <= DIN[0];
        irr    <= '0;
        isr    <= '0;
        ir_d   <= '0;
        imr    <= '0;
        irq_rq <= 1'b0;
      end else begin
        ir_d <= IR;
        irr  <= irr_n;
        isr  <= isr_n;
        if (icw2_wr) t <= DIN[6:3];
        if (ocw1) imr <= DIN;
        if (ocw3 && DIN[1]) ris <= DIN[0];
        // The chosen level is frozen until the ack so the vector stays stable.
        if (ack_take) begin
          irq_rq <= 1'b0;
        end else if (!irq_rq && pending) begin
          irq_rq     <= 1'b1;
          lvl        <= p_idx;
          irq_vector <= {t, p_idx, 2'b00};
        end
      end
    end
  end

`ifdef PIC_AEOI_EN
  always_ff @(posedge CLK_32M) begin
    if (reset || icw1) aeoi <= 1'b0;
    else if (icw4_wr)  aeoi <= DIN[1] & ic4;
  end
`else
  assign aeoi = 1'b0;
`endif

endmodule

// File: tb/tb_pic_71059.sv
// Scoreboard bench for pic_71059: vectors and register reads are queued as expectations.
module tb_pic_71059;

  logic       clk = 1'b0;
  logic       reset, CS, A0, IOWR, IORD, irq_ack;
  logic [7:0] DIN, DOUT, IR;
  logic       irq_rq;
  logic [8:0] irq_vector;

  pic_71059 #(.NUM_IR(8)) dut (
    .CLK_32M(clk), .reset(reset), .CS(CS), .A0(A0), .IOWR(IOWR), .IORD(IORD),
    .DIN(DIN), .DOUT(DOUT), .IR(IR), .irq_rq(irq_rq), .irq_vector(irq_vector),
    .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] vec;
    int         cyc;
  } vec_exp_t;

  vec_exp_t   vec_q[$];
  logic [7:0] rd_q[$];
  string      rd_name_q[$];
  vec_exp_t   e_m;
  logic [7:0] r_m;
  string      n_m;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       rq_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: irq_rq rising presents a vector, CS&IORD presents a read.
  always @(negedge clk) begin
    if (!reset) begin
      if (irq_rq && !rq_prev) begin
        if (vec_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_irq: got vector %0h expected no request", irq_vector);
        end else begin
          e_m = vec_q.pop_front();
          check("irq_vector", 32'(irq_vector), 32'(e_m.vec));
          if (e_m.cyc >= 0) check("irq_latency", cyc, e_m.cyc);
        end
      end
      if (CS && IORD) begin
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_read: got %0h expected none", DOUT);
        end else begin
          r_m = rd_q.pop_front();
          n_m = rd_name_q.pop_front();
          check(n_m, 32'(DOUT), 32'(r_m));
        end
      end
    end
    rq_prev = irq_rq;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a0, input logic [7:0] d);
    CS = 1'b1; A0 = a0; DIN = d; IOWR = 1'b1;
    tick();
    IOWR = 1'b0; CS = 1'b0;
    tick();
  endtask

  task automatic rd(input logic a0, input logic [7:0] exp, input string name);
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    CS = 1'b1; A0 = a0; IORD = 1'b1;
    tick();
    CS = 1'b0; IORD = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
  endtask

  task automatic edge_ir(input logic [7:0] m);
    IR = m;
    tick();
    IR = '0;
  endtask

  task automatic expect_vec(input logic [8:0] v, input int c);
    vec_exp_t e;
    e.vec = v;
    e.cyc = c;
    vec_q.push_back(e);
  endtask

  task automatic wait_vec(input int left, input string name);
    int budget;
    budget = 20;
    while (vec_q.size() > left && budget > 0) begin
      tick();
      budget--;
    end
    if (vec_q.size() > left) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no request within budget, expected vector %0h", name, vec_q[0].vec);
      vec_q.delete();
    end
  endtask

  task automatic init(input logic [7:0] icw1);
    wr(1'b0, icw1);
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; CS = 1'b0; A0 = 1'b0; IOWR = 1'b0; IORD = 1'b0;
    irq_ack = 1'b0; DIN = '0; IR = '0;
    repeat (3) tick();
    check("reset_irq_rq", 32'(irq_rq), 0);
    check("reset_vector", 32'(irq_vector), 0);
    reset = 1'b0;
    tick();
    rd(1'b1, 8'hFF, "reset_imr");
    rd(1'b0, 8'h00, "reset_irr");

    // ICW1 13, ICW2 20, ICW4 01, OCW1 FC
    init(8'h13);
    wr(1'b1, 8'hFC);
    rd(1'b1, 8'hFC, "imr_fc");

    expect_vec(9'h080, cyc + 2);
    edge_ir(8'h01);
    wait_vec(0, "ir0_vec");
    check("ir0_rq_held", 32'(irq_rq), 1);
    ack();
    check("ir0_rq_after_ack", 32'(irq_rq), 0);
    wr(1'b0, 8'h0B);
    rd(1'b0, 8'h01, "isr_after_ack");

    // IR1 blocked while IR0 is in service
    edge_ir(8'h02);
    repeat (4) tick();
    check("ir1_blocked", 32'(irq_rq), 0);
    expect_vec(9'h084, -1);
    wr(1'b0, 8'h20);
    wait_vec(0, "ir1_after_eoi");
    ack();
    rd(1'b0, 8'h02, "isr_ir1");
    wr(1'b0, 8'h61);
    rd(1'b0, 8'h00, "isr_spec_eoi");

    // Simultaneous IR0 and IR1
    expect_vec(9'h080, cyc + 2);
    expect_vec(9'h084, -1);
    edge_ir(8'h03);
    wait_vec(1, "both_first");
    ack();
    repeat (3) tick();
    check("both_second_blocked", 32'(irq_rq), 0);
    wr(1'b0, 8'h20);
    wait_vec(0, "both_second");
    ack();
    wr(1'b0, 8'h20);
    rd(1'b0, 8'h00, "isr_clear_both");

    // Masked IR2, then unmask
    wr(1'b1, 8'h04);
    edge_ir(8'h04);
    repeat (4) tick();
    check("ir2_masked", 32'(irq_rq), 0);
    wr(1'b0, 8'h0A);
    rd(1'b0, 8'h04, "irr_ir2");
    expect_vec(9'h088, -1);
    wr(1'b1, 8'h00);
    wait_vec(0, "ir2_unmasked");
    rd(1'b1, 8'h00, "imr_00");
    ack();
    rd(1'b0, 8'h00, "irr_after_ack");
    wr(1'b0, 8'h20);

    // ICW4 with AEOI requested
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h03);
    wr(1'b1, 8'h00);
    expect_vec(9'h080, cyc + 2);
    edge_ir(8'h01);
    wait_vec(0, "aeoi_vec");
    ack();
    wr(1'b0, 8'h0B);
`ifdef PIC_AEOI_EN
    rd(1'b0, 8'h00, "isr_aeoi");
`else
    rd(1'b0, 8'h01, "isr_aeoi");
    wr(1'b0, 8'h20);
`endif

    // ICW1 while a request is pending
    expect_vec(9'h08C, cyc + 2);
    edge_ir(8'h08);
    wait_vec(0, "ir3_vec");
    check("ir3_pending", 32'(irq_rq), 1);
    CS = 1'b1; A0 = 1'b0; DIN = 8'h13; IOWR = 1'b1;
    tick();
    check("icw1_drops_rq", 32'(irq_rq), 0);
    IOWR = 1'b0; CS = 1'b0;
    tick();
    wr(1'b1, 8'h20);
    wr(1'b1, 8'h01);
    rd(1'b1, 8'h00, "imr_after_icw1");

    // Level-triggered mode
    init(8'h1B);
    wr(1'b0, 8'h0A);
    expect_vec(9'h090, -1);
    IR = 8'h10;
    wait_vec(0, "level_vec");
    ack();
    rd(1'b0, 8'h10, "irr_level_held");
    IR = 8'h00;
    tick();
    rd(1'b0, 8'h00, "irr_level_drop");
    wr(1'b0, 8'h20);

    // Reset mid-sequence
    wr(1'b0, 8'h13);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    rd(1'b1, 8'hFF, "imr_after_reset");

    tick();
    check("vec_q_drained", vec_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
